// File: rtl/arvi_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// XLEN and PC_RESET defaults apply only if arvi_defines.svh has not already defined them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif

package arvi_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO: push at tail, pop at head, single-cycle flush.
// Pop on empty is ignored; push on full is accepted only if a pop frees the slot.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != DEPTH_C) || do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: owns the fetch PC, issues one word request at a time,
// and buffers returned words with their PCs for decode; redirect flushes and restarts fetch.
module fetch_unit
    import arvi_fetch_pkg::*;
#(
    parameter  int unsigned            XLEN       = `XLEN,
    parameter  logic [XLEN-1:0]        PC_RESET   = `PC_RESET,
    parameter  int unsigned            FIFO_DEPTH = 4,
    localparam int unsigned            CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_req,
    output logic [XLEN-1:0] o_addr,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [CW-1:0]   o_count
);

    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_next;

    logic              push;
    logic              pop;
    logic              flush;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              head_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   pc_inc;
    logic [CW-1:0]     occ_after_pop;
    logic [CW-1:0]     occ_after_push_pop;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .push_data ({i_mem_data, req_pc}),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    // Redirect suppresses the pop so a flushed head is never reported as consumed.
    always_comb begin
        head_valid         = (count != '0);
        pop                = head_valid && i_ready && !i_redirect;
        redirect_pc        = i_redirect_pc & ~XLEN'(3);
        pc_inc             = req_pc + STEP;
        occ_after_pop      = count - CW'(pop);
        occ_after_push_pop = count + CW'(1) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FS_IDLE;
            fetch_pc <= PC_RESET;
            req_pc   <= PC_RESET;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        push          = 1'b0;
        flush         = 1'b0;
        case (state)
            FS_IDLE: begin
                if (i_redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                    req_pc_next   = redirect_pc;
                    state_next    = FS_REQ;
                end else if (occ_after_pop < DEPTH_C) begin
                    req_pc_next = fetch_pc;
                    state_next  = FS_REQ;
                end
            end
            FS_REQ: begin
                if (i_mem_ready && i_redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                    req_pc_next   = redirect_pc;
                end else if (i_mem_ready) begin
                    push          = 1'b1;
                    fetch_pc_next = pc_inc;
                    if (occ_after_push_pop < DEPTH_C) begin
                        req_pc_next = pc_inc;
                    end else begin
                        state_next = FS_IDLE;
                    end
                end else if (i_redirect) begin
                    // Address must hold until the stale response arrives.
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                    state_next    = FS_DROP;
                end
            end
            FS_DROP: begin
                if (i_redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_pc;
                end
                if (i_mem_ready) begin
                    req_pc_next = i_redirect ? redirect_pc : fetch_pc;
                    state_next  = FS_REQ;
                end
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

    always_comb begin
        o_req   = (state != FS_IDLE);
        o_addr  = req_pc;
        o_valid = head_valid;
        o_inst  = head_valid ? head[2*XLEN-1:XLEN] : '0;
        o_pc    = head_valid ? head[XLEN-1:0] : '0;
        o_count = count;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect corner cases, wrap.
module tb_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] PC_RST = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_req;
    logic [31:0] o_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  o_count;

    logic mem_auto;
    logic mem_manual;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    assign mem_ready = o_req & (mem_auto | mem_manual);
    assign mem_data  = word_of(o_addr);

    fetch_unit #(
        .XLEN       (XLEN),
        .PC_RESET   (PC_RST),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_req         (o_req),
        .o_addr        (o_addr),
        .i_mem_ready   (mem_ready),
        .i_mem_data    (mem_data),
        .o_valid       (o_valid),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .i_ready       (ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_count       (o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        mem_auto = 1'b0; mem_manual = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        mem_auto = 1'b1; mem_manual = 1'b0;
        tick(); tick();
        n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b exp 0", o_req); end
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL rst_addr got %h exp %h", o_addr, PC_RST); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", o_valid); end
        n_vec++; if (o_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h exp 0", o_inst); end
        n_vec++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", o_pc); end
        n_vec++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", o_count); end
        rst = 1'b0;
        tick();
        n_vec++; if (o_req !== 1'b1) begin n_err++; $display("FAIL first_req got %0b exp 1", o_req); end
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL first_addr got %h exp %h", o_addr, PC_RST); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL first_valid got %0b exp 0", o_valid); end
    endtask

    task automatic test_steady();
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1; mem_auto = 1'b1;
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            pc = PC_RST + 32'(4 * k);
            n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL steady_valid[%0d] got %0b exp 1", k, o_valid); end
            n_vec++; if (o_pc !== pc) begin n_err++; $display("FAIL steady_pc[%0d] got %h exp %h", k, o_pc, pc); end
            n_vec++; if (o_inst !== word_of(pc)) begin n_err++; $display("FAIL steady_inst[%0d] got %h exp %h", k, o_inst, word_of(pc)); end
            n_vec++; if (o_count !== 3'd1) begin n_err++; $display("FAIL steady_count[%0d] got %0d exp 1", k, o_count); end
            n_vec++; if (o_addr !== pc + 32'd4) begin n_err++; $display("FAIL steady_addr[%0d] got %h exp %h", k, o_addr, pc + 32'd4); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready = 1'b0; mem_auto = 1'b1;
        repeat (5) tick();
        n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", o_count); end
        n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL full_req got %0b exp 0", o_req); end
        n_vec++; if (o_pc !== PC_RST) begin n_err++; $display("FAIL full_head_pc got %h exp %h", o_pc, PC_RST); end
        repeat (3) tick();
        n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL hold_count got %0d exp 4", o_count); end
        n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL hold_req got %0b exp 0", o_req); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_vec++; if (o_req !== 1'b1) begin n_err++; $display("FAIL pulse_req got %0b exp 1", o_req); end
        n_vec++; if (o_addr !== PC_RST + 32'd16) begin n_err++; $display("FAIL pulse_addr got %h exp %h", o_addr, PC_RST + 32'd16); end
        n_vec++; if (o_count !== 3'd3) begin n_err++; $display("FAIL pulse_count got %0d exp 3", o_count); end
        n_vec++; if (o_pc !== PC_RST + 32'd4) begin n_err++; $display("FAIL pulse_pc got %h exp %h", o_pc, PC_RST + 32'd4); end
        tick();
        n_vec++; if (o_count !== 3'd4) begin n_err++; $display("FAIL refill_count got %0d exp 4", o_count); end
        n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL refill_req got %0b exp 0", o_req); end
    endtask

    task automatic test_redirect_inflight();
        apply_reset();
        ready = 1'b1; mem_auto = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_vec++; if (o_req !== 1'b1) begin n_err++; $display("FAIL drop_req got %0b exp 1", o_req); end
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL drop_addr got %h exp %h", o_addr, PC_RST); end
        tick(); tick();
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL drop_addr_hold got %h exp %h", o_addr, PC_RST); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid got %0b exp 0", o_valid); end
        mem_manual = 1'b1;
        tick();
        mem_manual = 1'b0;
        n_vec++; if (o_addr !== 32'h100) begin n_err++; $display("FAIL after_drop_addr got %h exp 00000100", o_addr); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid got %0b exp 0", o_valid); end
        mem_auto = 1'b1;
        tick();
        n_vec++; if (o_pc !== 32'h100) begin n_err++; $display("FAIL after_drop_pc got %h exp 00000100", o_pc); end
        n_vec++; if (o_inst !== word_of(32'h100)) begin n_err++; $display("FAIL after_drop_inst got %h exp %h", o_inst, word_of(32'h100)); end
    endtask

    task automatic test_redirect_collision();
        apply_reset();
        ready = 1'b1; mem_auto = 1'b1;
        tick(); tick();
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL coll_pre_valid got %0b exp 1", o_valid); end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL coll_valid got %0b exp 0", o_valid); end
        n_vec++; if (o_count !== 3'd0) begin n_err++; $display("FAIL coll_count got %0d exp 0", o_count); end
        n_vec++; if (o_inst !== 32'h0) begin n_err++; $display("FAIL coll_inst_mask got %h exp 0", o_inst); end
        n_vec++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL coll_pc_mask got %h exp 0", o_pc); end
        n_vec++; if (o_addr !== 32'h200) begin n_err++; $display("FAIL coll_addr got %h exp 00000200", o_addr); end
        tick();
        n_vec++; if (o_pc !== 32'h200) begin n_err++; $display("FAIL coll_pc got %h exp 00000200", o_pc); end
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        n_vec++; if (o_addr !== 32'h200) begin n_err++; $display("FAIL align_addr got %h exp 00000200", o_addr); end
        tick();
        n_vec++; if (o_pc !== 32'h200) begin n_err++; $display("FAIL align_pc got %h exp 00000200", o_pc); end
        tick();
        n_vec++; if (o_pc !== 32'h204) begin n_err++; $display("FAIL align_next_pc got %h exp 00000204", o_pc); end
    endtask

    task automatic test_double_redirect();
        apply_reset();
        ready = 1'b1; mem_auto = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL dbl_addr_hold got %h exp %h", o_addr, PC_RST); end
        mem_manual = 1'b1;
        tick();
        mem_manual = 1'b0;
        n_vec++; if (o_addr !== 32'h400) begin n_err++; $display("FAIL dbl_addr got %h exp 00000400", o_addr); end
        mem_auto = 1'b1;
        tick();
        n_vec++; if (o_pc !== 32'h400) begin n_err++; $display("FAIL dbl_pc got %h exp 00000400", o_pc); end
    endtask

    task automatic test_wrap();
        apply_reset();
        ready = 1'b1; mem_auto = 1'b1;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        n_vec++; if (o_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc0 got %h exp fffffffc", o_pc); end
        tick();
        n_vec++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1 got %h exp 00000000", o_pc); end
        n_vec++; if (o_inst !== word_of(32'h0)) begin n_err++; $display("FAIL wrap_inst got %h exp %h", o_inst, word_of(32'h0)); end
    endtask

    task automatic test_reset_in_drop();
        apply_reset();
        ready = 1'b1; mem_auto = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (o_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got %0b exp 0", o_req); end
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL mid_rst_addr got %h exp %h", o_addr, PC_RST); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %0b exp 0", o_valid); end
        n_vec++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count got %0d exp 0", o_count); end
        tick();
        n_vec++; if (o_addr !== PC_RST) begin n_err++; $display("FAIL mid_rst_restart got %h exp %h", o_addr, PC_RST); end
        n_vec++; if (o_req !== 1'b1) begin n_err++; $display("FAIL mid_rst_restart_req got %0b exp 1", o_req); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_double_redirect();
        test_wrap();
        test_reset_in_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
